muxn_rr: RTL and testbench

Parametrised registered N-bit, CH-channel multiplexer with per-channel valid/ready handshake. It is the successor to the fixed 8:1 combinational mux. It adds a registered select, output backpressure, and an optional round-robin scan mode. It sits between CH producer channels and a single downstream consumer, and forwards one word per accepted transfer.

---
 rtl/muxn_rr.sv | 72 +++++++
 tb/tb_muxn_rr.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/muxn_rr.sv
// muxn_rr: registered CH-channel valid/ready mux with a loadable select; define MUXN_RR_EN to add round-robin scan mode
module muxn_rr #(
   parameter int N  = 64,
   parameter int CH = 8,
   parameter int SW = $clog2(CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CH*N-1:0] d,
   input  logic [CH-1:0]   d_valid,
   output logic [CH-1:0]   d_ready,
   input  logic [SW-1:0]   s,
   input  logic            s_load,
   input  logic            mode,
   output logic [N-1:0]    y,
   output logic [SW-1:0]   y_ch,
   output logic            y_valid,
   input  logic            y_ready,
   output logic            sel_err
);
   logic [N-1:0] dch [CH];
   logic [SW-1:0] sel_q, g;
   logic can_acc, g_en, fire, s_ok;
   for (genvar i = 0; i < CH; i++) begin : g_ch
      assign dch[i] = d[i*N +: N];
   end
   assign can_acc = !y_valid || y_ready;
   assign s_ok = 32'(s) < CH;
`ifdef MUXN_RR_EN
   logic [SW-1:0] ptr, g_rr;
   logic any_rr;
   // lowest circular offset from ptr wins, hence the descending scan
   always_comb begin
      g_rr = ptr;
      any_rr = 1'b0;
      for (int k = CH-1; k >= 0; k--) begin
         if (d_valid[SW'((int'(ptr) + k) % CH)]) begin
            g_rr = SW'((int'(ptr) + k) % CH);
            any_rr = 1'b1;
         end
      end
   end
   assign g = mode ? g_rr : sel_q;
   assign g_en = mode ? any_rr : 1'b1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else if (fire && mode) ptr <= (g == SW'(CH-1)) ? '0 : g + 1'b1;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign g = sel_q;
   assign g_en = 1'b1;
`endif
   assign fire = can_acc && d_valid[g];
   assign d_ready = (rst_n && can_acc && g_en) ? CH'(1) << g : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         y <= '0;
         y_ch <= '0;
         y_valid <= 1'b0;
         sel_q <= '0;
         sel_err <= 1'b0;
      end else begin
         if (fire) begin
            y <= dch[g];
            y_ch <= g;
            y_valid <= 1'b1;
         end else if (y_ready) y_valid <= 1'b0;
         if (s_load && s_ok) sel_q <= s;
         sel_err <= s_load && !s_ok;
      end
endmodule

// File: tb/tb_muxn_rr.sv
// tb_muxn_rr: directed vector bench for muxn_rr (CH=8 main instance, CH=6 instance for select range errors)
module tb_muxn_rr;
   logic clk, rst_n;
   logic [63:0] d;
   logic [7:0] d_valid, d_ready, y;
   logic [2:0] s, y_ch;
   logic s_load, mode, y_valid, y_ready, sel_err;
   logic [47:0] d6;
   logic [5:0] dv6, dr6;
   logic [2:0] s6, ych6;
   logic [7:0] y6;
   logic sl6, yv6, sel_err6;
   int checks = 0, errors = 0;

   typedef struct {
      int dv, sl, s, md, yr, base, edr, eyv, ey, ech;
   } vec_t;
   vec_t vec [32];
   int nv = 0;

   muxn_rr #(.N(8), .CH(8)) dut (
      .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .d_ready(d_ready),
      .s(s), .s_load(s_load), .mode(mode), .y(y), .y_ch(y_ch),
      .y_valid(y_valid), .y_ready(y_ready), .sel_err(sel_err));

   muxn_rr #(.N(8), .CH(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .d(d6), .d_valid(dv6), .d_ready(dr6),
      .s(s6), .s_load(sl6), .mode(1'b0), .y(y6), .y_ch(ych6),
      .y_valid(yv6), .y_ready(1'b1), .sel_err(sel_err6));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input vec_t v);
      vec[nv] = v;
      nv++;
   endtask

   task automatic set_data(input int base);
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(base + i);
   endtask

   initial begin
      add('{'h00, 1, 3, 0, 1, 14, 'h01, 0, 0, 0});
      add('{'hFF, 0, 0, 0, 1, 14, 'h08, 1, 17, 3});
      add('{'hFF, 0, 0, 0, 1, 20, 'h08, 1, 23, 3});
      add('{'h00, 0, 0, 0, 1, 20, 'h08, 0, 23, 3});
      add('{'h08, 0, 0, 0, 0, 30, 'h08, 1, 33, 3});
      add('{'hFF, 0, 0, 0, 0, 40, 'h00, 1, 33, 3});
      add('{'hFF, 0, 0, 0, 0, 50, 'h00, 1, 33, 3});
      add('{'hFF, 0, 0, 0, 0, 60, 'h00, 1, 33, 3});
      add('{'hFF, 0, 0, 0, 0, 70, 'h00, 1, 33, 3});
      add('{'hFF, 0, 0, 0, 1, 80, 'h08, 1, 83, 3});
      add('{'hFF, 1, 1, 0, 1, 90, 'h08, 1, 93, 3});
      add('{'hFF, 1, 3, 0, 1, 100, 'h02, 1, 101, 1});
      add('{'hFF, 0, 0, 0, 1, 110, 'h08, 1, 113, 3});
      add('{'h00, 0, 0, 0, 1, 110, 'h08, 0, 113, 3});
`ifdef MUXN_RR_EN
      add('{'hA5, 0, 0, 1, 1, 120, 'h01, 1, 120, 0});
      add('{'hA5, 0, 0, 1, 1, 130, 'h04, 1, 132, 2});
      add('{'hA5, 0, 0, 1, 1, 140, 'h20, 1, 145, 5});
      add('{'hA5, 0, 0, 1, 1, 150, 'h80, 1, 157, 7});
      add('{'hA5, 0, 0, 1, 1, 160, 'h01, 1, 160, 0});
      add('{'hA5, 0, 0, 1, 0, 170, 'h00, 1, 160, 0});
      add('{'hA5, 0, 0, 1, 1, 180, 'h04, 1, 182, 2});
      add('{'h00, 0, 0, 1, 1, 180, 'h00, 0, 182, 2});
      add('{'hA5, 1, 6, 1, 1, 190, 'h20, 1, 195, 5});
      add('{'hFF, 0, 0, 0, 1, 200, 'h40, 1, 206, 6});
      add('{'hA5, 0, 0, 1, 1, 210, 'h80, 1, 217, 7});
`else
      add('{'hA5, 0, 0, 1, 1, 120, 'h08, 0, 113, 3});
      add('{'hFF, 0, 0, 1, 1, 130, 'h08, 1, 133, 3});
`endif
      rst_n = 1'b0;
      d = '0;
      d_valid = 8'hFF;
      s = '0;
      s_load = 1'b0;
      mode = 1'b0;
      y_ready = 1'b1;
      d6 = '0;
      dv6 = '0;
      s6 = '0;
      sl6 = 1'b0;
      #1;
      chk("reset d_ready", 64'(d_ready), 64'h0);
      chk("reset y_valid", 64'(y_valid), 64'h0);
      chk("reset y", 64'(y), 64'h0);
      chk("reset y_ch", 64'(y_ch), 64'h0);
      chk("reset sel_err", 64'(sel_err), 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < nv; i++) begin
         d_valid = 8'(vec[i].dv);
         s_load = 1'(vec[i].sl);
         s = 3'(vec[i].s);
         mode = 1'(vec[i].md);
         y_ready = 1'(vec[i].yr);
         set_data(vec[i].base);
         #3;
         chk($sformatf("v%0d d_ready", i), 64'(d_ready), 64'(vec[i].edr));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d y_valid", i), 64'(y_valid), 64'(vec[i].eyv));
         chk($sformatf("v%0d y", i), 64'(y), 64'(vec[i].ey));
         chk($sformatf("v%0d y_ch", i), 64'(y_ch), 64'(vec[i].ech));
      end
      s_load = 1'b0;
      mode = 1'b0;
      d_valid = 8'hFF;
      y_ready = 1'b1;
      set_data(230);
      @(posedge clk);
      #1 y_ready = 1'b0;
      chk("pre-stall y_valid", 64'(y_valid), 64'h1);
      @(posedge clk);
      #1 chk("stall y_valid", 64'(y_valid), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst y_valid", 64'(y_valid), 64'h0);
      chk("async rst y", 64'(y), 64'h0);
      chk("async rst y_ch", 64'(y_ch), 64'h0);
      chk("async rst d_ready", 64'(d_ready), 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mode = 1'b1;
      y_ready = 1'b1;
      set_data(240);
      #3 chk("post rst d_ready", 64'(d_ready), 64'h01);
      @(posedge clk);
      #1;
      chk("post rst y_ch", 64'(y_ch), 64'h0);
      chk("post rst y", 64'(y), 64'd240);
      sl6 = 1'b1;
      s6 = 3'd2;
      @(posedge clk);
      #1 chk("ch6 good load sel_err", 64'(sel_err6), 64'h0);
      s6 = 3'd7;
      #3 chk("ch6 sel_q loaded", 64'(dr6), 64'h04);
      @(posedge clk);
      #1 sl6 = 1'b0;
      chk("ch6 bad load sel_err", 64'(sel_err6), 64'h1);
      chk("ch6 sel_q kept", 64'(dr6), 64'h04);
      @(posedge clk);
      #1 chk("ch6 sel_err one cycle", 64'(sel_err6), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
